// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// nibble/segment widths, the blank pattern, a counter-width helper and
// the active-low hex-to-segment decoder.
package seg7_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  // Segment pattern with every segment dark (active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hex nibble to segments {g,f,e,d,c,b,a}, active-low.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_prescale.sv
// Slot prescaler and digit/row index counter; usable for display or key scanning.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   div_cnt      cycle position inside the current slot, 0..DIV-1
//   dig          slot index, 0..COUNT-1, advances when div_cnt wraps
//   frame_end_c  combinational: last cycle of the last slot
module seg7_prescale import seg7_pkg::*; #(
  parameter  int unsigned DIV   = 65536,
  parameter  int unsigned COUNT = 8,
  localparam int unsigned DIV_W = cnt_w(DIV),
  localparam int unsigned DIG_W = cnt_w(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DIV_W-1:0] div_cnt,
  output logic [DIG_W-1:0] dig,
  output logic             frame_end_c
);

  logic slot_end_c;

  assign slot_end_c  = (div_cnt == DIV_W'(DIV - 1));
  assign frame_end_c = slot_end_c && (dig == DIG_W'(COUNT - 1));

  // Cycle counter wraps each slot; slot index wraps each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig     <= '0;
    end else if (slot_end_c) begin
      div_cnt <= '0;
      dig     <= frame_end_c ? '0 : dig + DIG_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment display driver with double-buffered loads,
// leading-zero and per-digit blanking, decimal points and PWM brightness.
// Ports:
//   clk, rst      board clock, asynchronous active-high reset
//   load          one-cycle strobe capturing in_data / dp_in / blank_mask
//   in_data       hex nibbles, digit 0 in bits [3:0] (rightmost)
//   dp_in         decimal point per digit, 1 = lit
//   blank_mask    1 = digit forced dark
//   lz_blank      live level, suppress leading zeros
//   brightness    live level, lit sub-slots per digit slot
//   display_data  segments {g,f,e,d,c,b,a}, active-low
//   display_dp    decimal point, active-low
//   display_en    digit anodes, active-low, at most one low
//   frame_done    one-cycle pulse after the last digit slot
module seg7_scan import seg7_pkg::*; #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 65536,
  parameter int unsigned BR_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NIB_W*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic                        lz_blank,
  input  logic [BR_W-1:0]             brightness,
  output logic [SEG_W-1:0]            display_data,
  output logic                        display_dp,
  output logic [NUM_DIGITS-1:0]       display_en,
  output logic                        frame_done
);

  localparam int unsigned DIV_W    = cnt_w(CLK_DIV);
  localparam int unsigned DIG_W    = cnt_w(NUM_DIGITS);
  localparam int unsigned DATA_W   = NIB_W * NUM_DIGITS;
  localparam int unsigned PWM_W    = DIV_W + BR_W;
  localparam int unsigned SUB_SLOT = CLK_DIV >> BR_W;

  logic [DIV_W-1:0]      div_cnt;
  logic [DIG_W-1:0]      dig;
  logic                  frame_end_c;

  logic [DATA_W-1:0]     act_data, pend_data;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  logic [NUM_DIGITS-1:0] act_blank, pend_blank;
  logic                  pend_valid;

  logic [NIB_W-1:0]      nib_c;
  logic                  dp_c, mask_c, lz_c, pwm_on_c, lit_c;
  logic [NUM_DIGITS-1:0] en_c;

  seg7_prescale #(
    .DIV   (CLK_DIV),
    .COUNT (NUM_DIGITS)
  ) u_prescale (
    .clk         (clk),
    .rst         (rst),
    .div_cnt     (div_cnt),
    .dig         (dig),
    .frame_end_c (frame_end_c)
  );

  // Double buffer: active only changes on a frame boundary; a load landing
  // on the boundary cycle itself bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else if (frame_end_c) begin
      if (load) begin
        act_data  <= in_data;
        act_dp    <= dp_in;
        act_blank <= blank_mask;
      end else if (pend_valid) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_data  <= in_data;
      pend_dp    <= dp_in;
      pend_blank <= blank_mask;
      pend_valid <= 1'b1;
    end
  end

  // Select the current digit; leading-zero flag is set when this nibble
  // and every more-significant nibble are zero (digit 0 is exempt).
  always_comb begin
    nib_c  = '0;
    dp_c   = 1'b0;
    mask_c = 1'b0;
    lz_c   = 1'b0;
    en_c   = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig == DIG_W'(i)) begin
        nib_c   = act_data[NIB_W*i +: NIB_W];
        dp_c    = act_dp[i];
        mask_c  = act_blank[i];
        lz_c    = (i != 0) && ((act_data >> (NIB_W * i)) == '0);
        en_c[i] = 1'b0;
      end
    end
  end

  // PWM: lit for the first brightness sub-slots of each digit slot.
  assign pwm_on_c = PWM_W'(div_cnt) < (PWM_W'(brightness) * PWM_W'(SUB_SLOT));
  assign lit_c    = pwm_on_c && !mask_c && !(lz_blank && lz_c);

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_en   <= '1;
      display_data <= SEG_BLANK;
      display_dp   <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      if (lit_c) begin
        display_en   <= en_c;
        display_data <= hex_to_seg(nib_c);
        display_dp   <= ~dp_c;
      end else begin
        display_en   <= '1;
        display_data <= SEG_BLANK;
        display_dp   <= 1'b1;
      end
    end
  end

endmodule
